// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped word cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } cache_state_t;

    // Helpers work on a 64-bit view so any address width up to 64 can use them.
    function automatic logic [63:0] line_index(input logic [63:0] addr, input int index_bits);
        return addr & ~({64{1'b1}} << index_bits);
    endfunction

    function automatic logic [63:0] line_tag(input logic [63:0] addr, input int index_bits);
        return addr >> index_bits;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Per-line valid/tag/data storage: one write port, one combinational read port.
module cache_line_store #(
    parameter int LINES      = 16,
    parameter int INDEX_BITS = 4,
    parameter int TAG_WIDTH  = 28,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [TAG_WIDTH-1:0]  write_tag,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [INDEX_BITS-1:0] read_index,
    output logic                  read_valid,
    output logic [TAG_WIDTH-1:0]  read_tag,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    // A write in the same cycle as a flush leaves that one line valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (flush)
                valid_q <= '0;
            if (write_en)
                valid_q[write_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) begin
            tag_q[write_index]  <= write_tag;
            data_q[write_index] <= write_data;
        end
    end

    assign read_valid = valid_q[read_index];
    assign read_tag   = tag_q[read_index];
    assign read_data  = data_q[read_index];

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of a req/ack RAM.
// state     | meaning
// IDLE      | accepting requests; read hits answered next cycle
// MEM_READ  | miss fill in flight, waiting for mem_ack
// MEM_WRITE | write-through in flight, waiting for mem_ack
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINES       = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic                   is_write,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic                   ready,
    output logic                   resp_valid,
    output logic [DATA_WIDTH-1:0]  output_data,
    input  logic                   flush,
    output logic                   mem_req,
    output logic                   mem_is_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]  mem_data,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_BITS;

    // Assertion is immediate; release is delayed two edges so all flops leave reset together.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    cache_state_t state_q, state_d;

    logic [INDEX_BITS-1:0] req_index, fill_index, store_windex;
    logic [TAG_WIDTH-1:0]  req_tag, fill_tag, store_wtag, rd_tag;
    logic [DATA_WIDTH-1:0] store_wdata, rd_data;
    logic                  rd_valid, hit, accept;
    logic                  store_we, store_flush;
    logic                  read_hit, read_miss, write_start, mem_done;

    assign req_index  = INDEX_BITS'(line_index(64'(address), INDEX_BITS));
    assign req_tag    = TAG_WIDTH'(line_tag(64'(address), INDEX_BITS));
    assign fill_index = INDEX_BITS'(line_index(64'(mem_address), INDEX_BITS));
    assign fill_tag   = TAG_WIDTH'(line_tag(64'(mem_address), INDEX_BITS));

    assign hit    = rd_valid && (rd_tag == req_tag);
    assign ready  = rst_int_n && (state_q == IDLE) && !flush;
    assign accept = req_valid && ready;

    cache_line_store #(
        .LINES      (LINES),
        .INDEX_BITS (INDEX_BITS),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clock       (clock),
        .reset_n     (rst_int_n),
        .flush       (store_flush),
        .write_en    (store_we),
        .write_index (store_windex),
        .write_tag   (store_wtag),
        .write_data  (store_wdata),
        .read_index  (req_index),
        .read_valid  (rd_valid),
        .read_tag    (rd_tag),
        .read_data   (rd_data)
    );

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // mem_req is high for the whole of MEM_READ/MEM_WRITE, so acks elsewhere are ignored.
    always_comb begin
        state_d      = state_q;
        store_we     = 1'b0;
        store_flush  = 1'b0;
        store_windex = req_index;
        store_wtag   = req_tag;
        store_wdata  = data;
        read_hit     = 1'b0;
        read_miss    = 1'b0;
        write_start  = 1'b0;
        mem_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    store_flush = 1'b1;
                end else if (accept) begin
                    if (is_write) begin
                        write_start = 1'b1;
                        store_we    = hit;
                        state_d     = MEM_WRITE;
                    end else if (hit) begin
                        read_hit = 1'b1;
                    end else begin
                        read_miss = 1'b1;
                        state_d   = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                if (mem_ack) begin
                    store_we     = 1'b1;
                    store_windex = fill_index;
                    store_wtag   = fill_tag;
                    store_wdata  = mem_read_data;
                    mem_done     = 1'b1;
                    state_d      = IDLE;
                end
            end
            MEM_WRITE: begin
                if (mem_ack) begin
                    mem_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            resp_valid   <= 1'b0;
            output_data  <= '0;
            mem_req      <= 1'b0;
            mem_is_write <= 1'b0;
            mem_address  <= '0;
            mem_data     <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (read_hit) begin
                resp_valid  <= 1'b1;
                output_data <= rd_data;
                if (hit_count != '1)
                    hit_count <= hit_count + COUNT_WIDTH'(1);
            end
            if (read_miss) begin
                mem_req      <= 1'b1;
                mem_is_write <= 1'b0;
                mem_address  <= address;
                if (miss_count != '1)
                    miss_count <= miss_count + COUNT_WIDTH'(1);
            end
            if (write_start) begin
                mem_req      <= 1'b1;
                mem_is_write <= 1'b1;
                mem_address  <= address;
                mem_data     <= data;
            end
            if (mem_done) begin
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                if (state_q == MEM_READ)
                    output_data <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench: directed scenarios plus randomized traffic against an address-level cache model.
module tb_direct_mapped_cache;

    localparam int AW = 32, DW = 32, LINES = 16, CW = 16;

    logic          clock = 1'b0;
    logic          reset_n, req_valid, is_write, flush, mem_ack;
    logic [AW-1:0] address, mem_address;
    logic [DW-1:0] data, output_data, mem_data, mem_read_data;
    logic          ready, resp_valid, mem_req, mem_is_write;
    logic [CW-1:0] hit_count, miss_count;

    always #5 clock = ~clock;

    direct_mapped_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINES(LINES), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .is_write(is_write),
        .address(address), .data(data), .ready(ready), .resp_valid(resp_valid),
        .output_data(output_data), .flush(flush), .mem_req(mem_req), .mem_is_write(mem_is_write),
        .mem_address(mem_address), .mem_data(mem_data), .mem_ack(mem_ack),
        .mem_read_data(mem_read_data), .hit_count(hit_count), .miss_count(miss_count)
    );

    int tests_run = 0, tests_failed = 0;

    // RAM seen by the DUT, and the bench's own shadow of what memory should hold.
    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : mem_init(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Cache model: which full address each line holds.
    bit          res_v    [LINES];
    logic [31:0] res_addr [LINES];
    int          exp_hits = 0, exp_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) res_v[i] = 0;
    endtask

    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                output bit was_hit, output logic [31:0] exp_data);
        int idx = int'(a % LINES);
        was_hit = res_v[idx] && (res_addr[idx] == a);
        if (w) ref_mem[a] = wd;
        else if (was_hit) exp_hits++;
        else begin exp_misses++; res_v[idx] = 1; res_addr[idx] = a; end
        exp_data = ref_rd(a);
    endtask

    // RAM responder: ack after ack_delay cycles of mem_req.
    int          ack_delay = 1, req_age = 0, xact_count = 0, last_req_cycles = 0, unstable = 0;
    bit          late_ack = 0;
    logic [31:0] last_addr, last_data, s_addr, s_data;
    logic        last_write, s_write;

    initial begin
        mem_ack = 0; mem_read_data = '0;
        forever begin
            @(negedge clock);
            mem_ack = 0;
            if (late_ack) begin
                mem_ack = 1; mem_read_data = 32'hBAD0BAD0; late_ack = 0;
            end else if (mem_req) begin
                if (req_age == 0) begin s_addr = mem_address; s_data = mem_data; s_write = mem_is_write; end
                else if ({s_addr, s_data, s_write} !== {mem_address, mem_data, mem_is_write}) unstable++;
                req_age++;
                if (req_age >= ack_delay) begin
                    mem_ack = 1; xact_count++; last_req_cycles = req_age;
                    last_addr = mem_address; last_write = mem_is_write; last_data = mem_data;
                    if (mem_is_write) ram[mem_address] = mem_data;
                    else mem_read_data = ram_rd(mem_address);
                    req_age = 0;
                end
            end else req_age = 0;
        end
    end

    // One CPU transaction; lat counts cycles from acceptance to response (1 = next cycle), -1 on timeout.
    task automatic cpu_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output int lat, output int xacts);
        int start, guard = 0;
        @(negedge clock);
        req_valid = 1; is_write = w; address = a; data = wd;
        #1;
        while (!ready && guard < 50) begin @(negedge clock); #1; guard++; end
        start = xact_count;
        @(negedge clock);
        req_valid = 0; lat = 1;
        while (!resp_valid && lat < 200) begin @(negedge clock); lat++; end
        if (!resp_valid) lat = -1;
        rd = output_data; xacts = xact_count - start;
    endtask

    task automatic test_reset();
        reset_n = 0; req_valid = 0; is_write = 0; flush = 0; address = '0; data = '0;
        model_clear(); exp_hits = 0; exp_misses = 0;
        repeat (2) @(negedge clock);
        tests_run++; if ({ready, resp_valid, mem_req, mem_is_write} !== 4'b0000) begin tests_failed++;
            $display("FAIL reset_flags: got %b want 0000", {ready, resp_valid, mem_req, mem_is_write}); end
        tests_run++; if ({output_data, mem_address, mem_data} !== 96'd0) begin tests_failed++;
            $display("FAIL reset_regs: got %h %h %h want zeros", output_data, mem_address, mem_data); end
        tests_run++; if ({hit_count, miss_count} !== 32'd0) begin tests_failed++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        reset_n = 1;
        repeat (3) @(negedge clock);
        tests_run++; if (ready !== 1'b1) begin tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", ready); end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd, ed; int lat, x; bit h;
        ack_delay = 3;
        model_access(0, 32'h25, 0, h, ed);
        cpu_access(0, 32'h25, 0, rd, lat, x);
        tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL cold_data: got %h want deadbeef", rd); end
        tests_run++; if (lat !== 4) begin tests_failed++;
            $display("FAIL cold_latency: got %0d want 4", lat); end
        tests_run++; if ({last_req_cycles, last_addr, last_write} !== {32'd3, 32'h25, 1'b0}) begin tests_failed++;
            $display("FAIL cold_mem_req: cycles %0d addr %h wr %b want 3 25 0", last_req_cycles, last_addr, last_write); end
        tests_run++; if (miss_count !== 16'd1 || x !== 1) begin tests_failed++;
            $display("FAIL cold_miss_count: got %0d xacts %0d want 1 1", miss_count, x); end
    endtask

    task automatic test_back_to_back();
        int start = xact_count;
        @(negedge clock);
        req_valid = 1; is_write = 0; address = 32'h25;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            tests_run++; if ({resp_valid, output_data} !== {1'b1, 32'hDEADBEEF}) begin tests_failed++;
                $display("FAIL b2b_resp%0d: got %b %h want 1 deadbeef", k, resp_valid, output_data); end
            if (k == 4) req_valid = 0;
        end
        exp_hits += 4;
        @(negedge clock);
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++;
            $display("FAIL b2b_extra_resp: got %b want 0", resp_valid); end
        tests_run++; if (hit_count !== 16'd4 || xact_count != start) begin tests_failed++;
            $display("FAIL b2b_hits: got %0d xacts %0d want 4 0", hit_count, xact_count - start); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, ed; int lat, x; bit h;
        ack_delay = 2;
        model_access(1, 32'h25, 32'h12345678, h, ed);
        cpu_access(1, 32'h25, 32'h12345678, rd, lat, x);
        tests_run++; if ({last_write, last_addr, last_data} !== {1'b1, 32'h25, 32'h12345678}) begin tests_failed++;
            $display("FAIL wr_mem: got %b %h %h want 1 25 12345678", last_write, last_addr, last_data); end
        tests_run++; if (lat !== 3 || rd !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL wr_resp: lat %0d data %h want 3 deadbeef", lat, rd); end
        model_access(0, 32'h25, 0, h, ed);
        cpu_access(0, 32'h25, 0, rd, lat, x);
        tests_run++; if (rd !== 32'h12345678 || x !== 0 || lat !== 1) begin tests_failed++;
            $display("FAIL wr_readback: data %h xacts %0d lat %0d want 12345678 0 1", rd, x, lat); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd, ed; int lat, x; bit h;
        model_access(1, 32'h07, 32'hCAFEF00D, h, ed);
        cpu_access(1, 32'h07, 32'hCAFEF00D, rd, lat, x);
        model_access(0, 32'h07, 0, h, ed);
        cpu_access(0, 32'h07, 0, rd, lat, x);
        tests_run++; if (rd !== 32'hCAFEF00D || x !== 1) begin tests_failed++;
            $display("FAIL wmiss_read: data %h xacts %0d want cafef00d 1", rd, x); end
        tests_run++; if (miss_count !== 16'd2) begin tests_failed++;
            $display("FAIL wmiss_count: got %0d want 2", miss_count); end
    endtask

    task automatic test_alias();
        logic [31:0] rd, ed; int lat, x; bit h;
        logic [31:0] seq [3];
        seq[0] = 32'h05; seq[1] = 32'h15; seq[2] = 32'h05;
        for (int i = 0; i < 3; i++) begin
            model_access(0, seq[i], 0, h, ed);
            cpu_access(0, seq[i], 0, rd, lat, x);
            tests_run++; if (rd !== mem_init(seq[i]) || x !== 1) begin tests_failed++;
                $display("FAIL alias_%0d: data %h xacts %0d want %h 1", i, rd, x, mem_init(seq[i])); end
        end
        tests_run++; if (miss_count !== 16'd5) begin tests_failed++;
            $display("FAIL alias_count: got %0d want 5", miss_count); end
    endtask

    task automatic test_flush();
        logic [31:0] rd, ed; int lat, x; bit h;
        @(negedge clock);
        flush = 1; req_valid = 1; is_write = 0; address = 32'h25;
        #1;
        tests_run++; if (ready !== 1'b0) begin tests_failed++;
            $display("FAIL flush_ready: got %b want 0", ready); end
        @(negedge clock);
        flush = 0; req_valid = 0;
        tests_run++; if ({resp_valid, mem_req} !== 2'b00) begin tests_failed++;
            $display("FAIL flush_accepted: resp %b mem_req %b want 0 0", resp_valid, mem_req); end
        model_clear();
        model_access(0, 32'h25, 0, h, ed);
        cpu_access(0, 32'h25, 0, rd, lat, x);
        tests_run++; if (rd !== 32'h12345678 || x !== 1 || miss_count !== 16'd6) begin tests_failed++;
            $display("FAIL flush_refetch: data %h xacts %0d misses %0d want 12345678 1 6", rd, x, miss_count); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ed, a, wd; int lat, x, r; bit h, w;
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clock); flush = 1;
                @(negedge clock); flush = 0;
                model_clear();
            end else begin
                w = (r < 4); a = $urandom_range(0, 47); wd = $urandom;
                ack_delay = $urandom_range(1, 4);
                model_access(w, a, wd, h, ed);
                cpu_access(w, a, wd, rd, lat, x);
                if (w) begin
                    tests_run++; if (x !== 1 || lat !== ack_delay + 1 || last_data !== wd || last_addr !== a) begin tests_failed++;
                        $display("FAIL rand_write_%0d: xacts %0d lat %0d data %h addr %h want 1 %0d %h %h",
                                 it, x, lat, last_data, last_addr, ack_delay + 1, wd, a); end
                end else begin
                    tests_run++; if (rd !== ed) begin tests_failed++;
                        $display("FAIL rand_read_data_%0d: addr %h got %h want %h", it, a, rd, ed); end
                    tests_run++; if (x !== (h ? 0 : 1) || lat !== (h ? 1 : ack_delay + 1)) begin tests_failed++;
                        $display("FAIL rand_read_timing_%0d: addr %h xacts %0d lat %0d want %0d %0d",
                                 it, a, x, lat, h ? 0 : 1, h ? 1 : ack_delay + 1); end
                end
            end
        end
        tests_run++; if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin tests_failed++;
            $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
        tests_run++; if (unstable !== 0) begin tests_failed++;
            $display("FAIL mem_stable: got %0d changes want 0", unstable); end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] rd, ed; int lat, x, bad = 0; bit h;
        ack_delay = 100;
        @(negedge clock);
        req_valid = 1; is_write = 0; address = 32'h1003;
        @(negedge clock);
        req_valid = 0;
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++;
            $display("FAIL inflight_req: got %b want 1", mem_req); end
        #2 reset_n = 0;
        #1;
        tests_run++; if ({mem_req, ready, hit_count, miss_count} !== 34'd0) begin tests_failed++;
            $display("FAIL inflight_reset: mem_req %b ready %b counts %0d/%0d want 0 0 0/0",
                     mem_req, ready, hit_count, miss_count); end
        @(negedge clock);
        reset_n = 1; model_clear(); exp_hits = 0; exp_misses = 0;
        #1 late_ack = 1;
        repeat (4) begin @(negedge clock); if (resp_valid !== 1'b0 || mem_req !== 1'b0) bad++; end
        tests_run++; if (bad !== 0) begin tests_failed++;
            $display("FAIL late_ack_ignored: got %0d bad cycles want 0", bad); end
        ack_delay = 2;
        model_access(0, 32'h1003, 0, h, ed);
        cpu_access(0, 32'h1003, 0, rd, lat, x);
        tests_run++; if (rd !== ed || x !== 1 || miss_count !== 16'd1) begin tests_failed++;
            $display("FAIL post_reset_read: data %h xacts %0d misses %0d want %h 1 1", rd, x, miss_count, ed); end
    endtask

    initial begin
        ram[32'h25] = 32'hDEADBEEF;
        ref_mem[32'h25] = 32'hDEADBEEF;
        test_reset();
        test_cold_read();
        test_back_to_back();
        test_write_hit();
        test_write_miss();
        test_alias();
        test_flush();
        test_random();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
